// File: rtl/diamond_hit_detector.sv
// Diamond collection detector: counts player/diamond overlap pixels per frame,
// then reports each newly collected diamond as a one-cycle pulse at frame start.

module diamond_hit_counter #(
  parameter int HIT_MIN_PIXELS = 4
) (
  input  logic clk,
  input  logic resetN,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_hit
);

  logic [3:0] r_cnt;

  // Clear wins over increment; the counter sticks at 15 instead of wrapping.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)                    r_cnt <= '0;
    else if (i_clr)                 r_cnt <= '0;
    else if (i_inc && r_cnt != 4'hF) r_cnt <= r_cnt + 4'd1;
  end

  assign o_hit = (r_cnt >= 4'(HIT_MIN_PIXELS));

endmodule

module diamond_hit_detector #(
  parameter int NUM_DIAMONDS   = 8,
  parameter int HIT_MIN_PIXELS = 4
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic                    drawingRequestBumpy,
  input  logic                    drawingRequestDiamond,
  input  logic [2:0]              diamondId,
  input  logic                    levelClear,
  output logic                    SHP_bumpyDiamond,
  output logic [2:0]              hitId,
  output logic [NUM_DIAMONDS-1:0] collectedMask,
  output logic                    allCollected
);

  typedef enum logic {SCAN, REPORT} state_t;

  state_t                  r_state;
  logic [NUM_DIAMONDS-1:0] r_pending;
  logic [NUM_DIAMONDS-1:0] w_inc;
  logic [NUM_DIAMONDS-1:0] w_hit;
  logic [NUM_DIAMONDS-1:0] w_hits;
  logic [NUM_DIAMONDS-1:0] w_src;
  logic [NUM_DIAMONDS-1:0] w_pick;
  logic [2:0]              w_pick_id;
  logic                    w_scan;
  logic                    w_ovl;
  logic                    w_clr;

  assign w_scan = (r_state == SCAN);
  assign w_ovl  = w_scan & drawingRequestBumpy & drawingRequestDiamond;
  assign w_clr  = levelClear | (w_scan & startOfFrame);

  // Ids at or above NUM_DIAMONDS match no lane and are dropped naturally.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIAMONDS; gi++) begin : g_lane
      assign w_inc[gi] = w_ovl && (diamondId == 3'(gi)) && !collectedMask[gi];
      diamond_hit_counter #(.HIT_MIN_PIXELS(HIT_MIN_PIXELS)) u_cnt (
        .clk    (clk),
        .resetN (resetN),
        .i_inc  (w_inc[gi]),
        .i_clr  (w_clr),
        .o_hit  (w_hit[gi])
      );
    end
  endgenerate

  assign w_hits = w_hit & ~collectedMask;
  // At frame start the first hit is emitted straight from the fresh hit set.
  assign w_src  = w_scan ? w_hits : r_pending;
  assign w_pick = w_src & (~w_src + 1'b1);

  always_comb begin
    w_pick_id = '0;
    for (int i = NUM_DIAMONDS - 1; i >= 0; i--)
      if (w_src[i]) w_pick_id = 3'(i);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state          <= SCAN;
      r_pending        <= '0;
      SHP_bumpyDiamond <= 1'b0;
      hitId            <= '0;
      collectedMask    <= '0;
    end else if (levelClear) begin
      r_state          <= SCAN;
      r_pending        <= '0;
      SHP_bumpyDiamond <= 1'b0;
      collectedMask    <= '0;
    end else begin
      case (r_state)
        SCAN: begin
          if (startOfFrame && |w_hits) begin
            r_state          <= REPORT;
            SHP_bumpyDiamond <= 1'b1;
            hitId            <= w_pick_id;
            collectedMask    <= collectedMask | w_pick;
            r_pending        <= w_hits & ~w_pick;
          end else begin
            SHP_bumpyDiamond <= 1'b0;
          end
        end
        REPORT: begin
          if (|r_pending) begin
            SHP_bumpyDiamond <= 1'b1;
            hitId            <= w_pick_id;
            collectedMask    <= collectedMask | w_pick;
            r_pending        <= r_pending & ~w_pick;
          end else begin
            SHP_bumpyDiamond <= 1'b0;
            r_state          <= SCAN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) allCollected <= 1'b0;
    else         allCollected <= &collectedMask;
  end

endmodule

// File: tb/tb_diamond_hit_detector.sv
// Directed bench for diamond_hit_detector with hand-computed expectations.

module tb_diamond_hit_detector;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame;
  logic       drawingRequestBumpy;
  logic       drawingRequestDiamond;
  logic [2:0] diamondId;
  logic       levelClear;
  logic       SHP_bumpyDiamond;
  logic [2:0] hitId;
  logic [7:0] collectedMask;
  logic       allCollected;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  diamond_hit_detector #(.NUM_DIAMONDS(8), .HIT_MIN_PIXELS(4)) dut (
    .clk                   (clk),
    .resetN                (resetN),
    .startOfFrame          (startOfFrame),
    .drawingRequestBumpy   (drawingRequestBumpy),
    .drawingRequestDiamond (drawingRequestDiamond),
    .diamondId             (diamondId),
    .levelClear            (levelClear),
    .SHP_bumpyDiamond      (SHP_bumpyDiamond),
    .hitId                 (hitId),
    .collectedMask         (collectedMask),
    .allCollected          (allCollected)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one pixel of inputs, then return just after the edge that consumed it.
  task automatic cyc(input logic sof, input logic b, input logic d,
                     input logic [2:0] id, input logic lc);
    startOfFrame          = sof;
    drawingRequestBumpy   = b;
    drawingRequestDiamond = d;
    diamondId             = id;
    levelClear            = lc;
    @(posedge clk); #1;
    startOfFrame = 1'b0; drawingRequestBumpy = 1'b0; drawingRequestDiamond = 1'b0;
    diamondId = 3'd0; levelClear = 1'b0;
  endtask

  task automatic overlap(input logic [2:0] id, input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, 1'b1, id, 1'b0);
  endtask

  task automatic pulse(input string tag, input logic [2:0] id, input logic [7:0] mask);
    chk({tag, "_shp"},  32'(SHP_bumpyDiamond), 32'd1);
    chk({tag, "_id"},   32'(hitId),            32'(id));
    chk({tag, "_mask"}, 32'(collectedMask),    32'(mask));
  endtask

  task automatic quiet(input string tag, input logic [7:0] mask);
    chk({tag, "_shp"},  32'(SHP_bumpyDiamond), 32'd0);
    chk({tag, "_mask"}, 32'(collectedMask),    32'(mask));
  endtask

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; drawingRequestBumpy = 1'b0;
    drawingRequestDiamond = 1'b0; diamondId = 3'd0; levelClear = 1'b0;
    #2;
    chk("rst_shp",  32'(SHP_bumpyDiamond), 32'd0);
    chk("rst_id",   32'(hitId),            32'd0);
    chk("rst_mask", 32'(collectedMask),    32'd0);
    chk("rst_all",  32'(allCollected),     32'd0);
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;

    // Single hit on the first frame after reset.
    overlap(3'd2, 4);
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    pulse("single", 3'd2, 8'h04);
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    quiet("single_after", 8'h04);

    // Below threshold, and the count does not carry across frames.
    overlap(3'd5, 3);
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    quiet("under_a", 8'h04);
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    overlap(3'd5, 3);
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    quiet("under_b", 8'h04);
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

    cyc(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    quiet("lc1", 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

    // Three hits; 17 pixels on diamond 6 would wrap to 1 without saturation.
    overlap(3'd6, 17);
    overlap(3'd1, 4);
    overlap(3'd3, 5);
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    pulse("multi0", 3'd1, 8'h02);
    cyc(1'b1, 1'b1, 1'b1, 3'd0, 1'b0);  // frame start and overlap ignored mid-report
    pulse("multi1", 3'd3, 8'h0A);
    cyc(1'b0, 1'b1, 1'b1, 3'd0, 1'b0);
    pulse("multi2", 3'd6, 8'h4A);
    cyc(1'b0, 1'b1, 1'b1, 3'd0, 1'b0);
    quiet("multi_end", 8'h4A);
    cyc(1'b0, 1'b1, 1'b1, 3'd0, 1'b0);  // one real overlap on diamond 0

    // Collected diamond 1 cannot be reported again; diamond 0 has only 1 pixel.
    overlap(3'd1, 10);
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    quiet("recollect", 8'h4A);
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

    // Collect the remaining five.
    overlap(3'd7, 4); overlap(3'd0, 4); overlap(3'd5, 6); overlap(3'd2, 4); overlap(3'd4, 4);
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    pulse("all0", 3'd0, 8'h4B);
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    pulse("all1", 3'd2, 8'h4F);
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    pulse("all2", 3'd4, 8'h5F);
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    pulse("all3", 3'd5, 8'h7F);
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    pulse("all4", 3'd7, 8'hFF);
    chk("all_lag", 32'(allCollected), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    quiet("all_end", 8'hFF);
    chk("all_set", 32'(allCollected), 32'd1);

    cyc(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    quiet("lc2", 8'h00);
    chk("lc2_all_lag", 32'(allCollected), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("lc2_all_clr", 32'(allCollected), 32'd0);

    // Level clear beats a coincident frame start with a pending hit.
    overlap(3'd3, 5);
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
    quiet("lc_sof", 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    quiet("lc_sof_next", 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    quiet("lc_cnt_clr", 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

    // Reset during the second pulse of a three-hit report.
    overlap(3'd1, 4); overlap(3'd4, 4); overlap(3'd7, 4);
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    pulse("rr0", 3'd1, 8'h02);
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    pulse("rr1", 3'd4, 8'h12);
    resetN = 1'b0;
    #1;
    quiet("rr_rst", 8'h00);
    chk("rr_rst_id", 32'(hitId), 32'd0);
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
      quiet("rr_idle", 8'h00);
    end
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    quiet("rr_sof", 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    overlap(3'd0, 4);
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    pulse("rr_new", 3'd0, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/diamond_hit_detector.md
DIAMOND_HIT_DETECTOR -- requirements
Module: diamond_hit_detector

Interface
REQ-001 Parameter NUM_DIAMONDS, default 8, SHALL set the number of collectable diamonds (range 2..8).
REQ-002 Parameter HIT_MIN_PIXELS, default 4, SHALL set the overlap pixels per frame a diamond needs to count as hit (range 1..15).
REQ-003 clk  input  1  SHALL be the pixel clock; all state changes on its rising edge.
REQ-004 resetN  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 startOfFrame  input  1  SHALL be a one-cycle pulse marking frame start (vertical blanking).
REQ-006 drawingRequestBumpy  input  1  SHALL be high when the player sprite is drawn at the current pixel.
REQ-007 drawingRequestDiamond  input  1  SHALL be high when any diamond is drawn at the current pixel.
REQ-008 diamondId  input  3  SHALL be the index of the diamond drawn; valid only with drawingRequestDiamond.
REQ-009 levelClear  input  1  SHALL be a one-cycle request to restore all diamonds (new level).
REQ-010 SHP_bumpyDiamond  output  1  SHALL be a one-cycle pulse per newly collected diamond; feeds the score counter.
REQ-011 hitId  output  3  SHALL hold the index of the diamond reported by the current or last pulse.
REQ-012 collectedMask  output  NUM_DIAMONDS  SHALL have bit i set once diamond i is collected; the drawer hides set diamonds.
REQ-013 allCollected  output  1  SHALL be high when every bit of collectedMask is set.

Function
REQ-014 The FSM SHALL have two states: SCAN (accumulate overlaps) and REPORT (emit pulses).
REQ-015 In SCAN, a pixel with drawingRequestBumpy and drawingRequestDiamond high, diamondId < NUM_DIAMONDS, and collectedMask[diamondId] clear SHALL increment that diamond's 4-bit overlap counter.
REQ-016 Each overlap counter SHALL saturate at 15; no wrap-around.
REQ-017 A diamondId >= NUM_DIAMONDS SHALL be ignored.
REQ-018 On startOfFrame in SCAN, every diamond whose counter is >= HIT_MIN_PIXELS SHALL be set in an internal pendingMask, all counters SHALL clear, and the FSM SHALL enter REPORT on the next cycle.
REQ-019 If pendingMask is empty at startOfFrame, the FSM SHALL remain in SCAN with counters cleared.
REQ-020 In REPORT, each cycle SHALL report the lowest-index pending bit: pulse SHP_bumpyDiamond, drive hitId, set that collectedMask bit, clear that pendingMask bit.
REQ-021 Pulses for k pending diamonds SHALL occur on k consecutive cycles; the FSM SHALL return to SCAN the cycle after the last pulse.
REQ-022 Drawing requests SHALL be ignored in REPORT; the first report cycle SHALL be the cycle after startOfFrame.
REQ-023 A startOfFrame arriving in REPORT SHALL be ignored; reporting SHALL continue.
REQ-024 A diamond SHALL be reported at most once between levelClear events, regardless of later overlaps.
REQ-025 levelClear SHALL on the next edge clear collectedMask, pendingMask and all counters, deassert SHP_bumpyDiamond and force SCAN.
REQ-026 levelClear SHALL take priority over startOfFrame and any REPORT activity in the same cycle.
REQ-027 allCollected SHALL be registered and update the cycle after collectedMask changes.

Reset
REQ-028 While resetN is low: state SCAN; SHP_bumpyDiamond 0; hitId 0; collectedMask 0; pendingMask 0; counters 0; allCollected 0.
REQ-029 Reset assertion mid-REPORT SHALL abort reporting immediately, with no further pulses after release.
REQ-030 The first startOfFrame after reset release SHALL be treated as a normal frame boundary.

Verification
REQ-031 Overlap diamond 2 for 4 pixels, then startOfFrame -> one pulse, hitId=2, collectedMask=0x04, on the cycle after startOfFrame.
REQ-032 Overlap diamond 5 for 3 pixels, then startOfFrame -> no pulse; counter cleared; next frame needs 4 new pixels.
REQ-033 Overlap diamonds 6, 1 and 3 (>= 4 pixels each), then startOfFrame -> pulses on 3 consecutive cycles, hitId 1,3,6; collectedMask=0x4A.
REQ-034 Re-overlap collected diamond 1 for 10 pixels, then startOfFrame -> no pulse; collectedMask unchanged.
REQ-035 Collect all 8 diamonds -> allCollected=1; levelClear coincident with startOfFrame and pending hits -> no pulses; collectedMask=0; allCollected=0 one cycle later.
REQ-036 Assert resetN low during the second pulse of a 3-hit REPORT -> outputs zero at once; no pulses after release until a new qualifying frame.
